clk_div_multi: RTL and testbench

- Multi-channel programmable clock divider; successor to the fixed divide-by-4, 50%-duty divider.
- Each of NUM_CH channels produces a registered divided clock with runtime period and high time, plus a one-cycle wrap tick.
- Reconfiguration is glitch-free via a valid/ready handshake.
- Feeds peripheral timing (display scan, audio, debouncers) from the single board clock CLK.

---
 rtl/clk_div_pkg.sv | 31 +++
 rtl/clk_div_multi_if.sv | 29 ++
 rtl/clk_div_chan.sv | 75 +++++++
 rtl/clk_div_multi.sv | 66 ++++++
 tb/tb_clk_div_multi.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants, channel-index width and configuration clamping for the
// multi-channel clock divider.
package clk_div_pkg;

    localparam int CNT_W_DEFAULT = 16;
    localparam int DIV_DEFAULT   = 4;
    localparam int HI_DEFAULT    = 2;

    typedef struct packed {
        logic [31:0] n;
        logic [31:0] h;
        logic [31:0] lo;
    } cfg_t;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Any request becomes a legal waveform: at least one low and one high cycle.
    function automatic cfg_t clamp_cfg(input logic [31:0] n, input logic [31:0] h);
        cfg_t c;
        c.n  = (n < 32'd2) ? 32'd2 : n;
        c.h  = (h == 32'd0) ? 32'd1 : h;
        if (c.h >= c.n) begin
            c.h = c.n - 32'd1;
        end
        c.lo = c.n - c.h;
        return c;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Run-enable, configuration handshake and divided-clock outputs of clk_div_multi.
interface clk_div_multi_if
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = CNT_W_DEFAULT
);
    localparam int CH_W = ch_width(NUM_CH);

    logic [NUM_CH-1:0] en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [CNT_W-1:0]  cfg_hi;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    modport master (
        output en, cfg_valid, cfg_ch, cfg_div, cfg_hi,
        input  cfg_ready, clk_out, tick
    );

    modport slave (
        input  en, cfg_valid, cfg_ch, cfg_div, cfg_hi,
        output cfg_ready, clk_out, tick
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active period/low time, shadow config with a
// pending flag that is applied only at a period boundary, and registered outputs.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int DEF_DIV = DIV_DEFAULT,
    parameter int DEF_HI  = HI_DEFAULT
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             en,
    input  logic             align,
    input  logic             load,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_hi,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] lo_q;
    logic [CNT_W-1:0] sh_n;
    logic [CNT_W-1:0] sh_lo;
    logic [CNT_W-1:0] req_n;
    logic [CNT_W-1:0] req_lo;
    cfg_t             req;
    logic             unused_req;
    logic             wrap;
    logic             apply;

    // Only N and the precomputed low time are kept; H itself is never needed again.
    assign req        = clamp_cfg(32'(cfg_div), 32'(cfg_hi));
    assign req_n      = CNT_W'(req.n);
    assign req_lo     = CNT_W'(req.lo);
    assign unused_req = ^req;

    assign wrap  = en && (cnt == n_q - CNT_W'(1));
    assign apply = pending && (!en || align || wrap);

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            n_q     <= CNT_W'(DEF_DIV);
            lo_q    <= CNT_W'(DEF_DIV - DEF_HI);
            sh_n    <= CNT_W'(DEF_DIV);
            sh_lo   <= CNT_W'(DEF_DIV - DEF_HI);
            pending <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (!en || align) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else begin
                cnt     <= wrap ? '0 : cnt + CNT_W'(1);
                clk_out <= (cnt >= lo_q);
                tick    <= wrap;
            end
            if (apply) begin
                n_q  <= sh_n;
                lo_q <= sh_lo;
            end
            if (load) begin
                sh_n  <= req_n;
                sh_lo <= req_lo;
            end
            pending <= load || (pending && !apply);
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: handshake decode and ready mux over
// NUM_CH channels. Optional CLK_DIV_PHASE_ALIGN_EN adds an align input.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int DEF_DIV = DIV_DEFAULT,
    parameter int DEF_HI  = HI_DEFAULT
) (
    input  logic CLK,
    input  logic rst,
`ifdef CLK_DIV_PHASE_ALIGN_EN
    input  logic align,
`endif
    clk_div_multi_if.slave bus
);

    localparam int CH_W = ch_width(NUM_CH);

    logic [NUM_CH-1:0]    pending;
    logic [NUM_CH-1:0]    clk_vec;
    logic [NUM_CH-1:0]    tick_vec;
    logic [2**CH_W-1:0]   pend_ext;
    logic                 ready;
    logic                 transfer;
    logic                 align_int;

`ifdef CLK_DIV_PHASE_ALIGN_EN
    assign align_int = align;
`else
    assign align_int = 1'b0;
`endif

    // Unused channel codes read as not pending, so such requests are taken and dropped.
    always_comb begin
        pend_ext               = '0;
        pend_ext[NUM_CH-1:0]   = pending;
    end

    assign ready         = !pend_ext[bus.cfg_ch];
    assign transfer      = bus.cfg_valid && ready;
    assign bus.cfg_ready = ready;
    assign bus.clk_out   = clk_vec;
    assign bus.tick      = tick_vec;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV),
            .DEF_HI  (DEF_HI)
        ) u_chan (
            .CLK     (CLK),
            .rst     (rst),
            .en      (bus.en[i]),
            .align   (align_int),
            .load    (transfer && (bus.cfg_ch == CH_W'(i))),
            .cfg_div (bus.cfg_div),
            .cfg_hi  (bus.cfg_hi),
            .pending (pending[i]),
            .clk_out (clk_vec[i]),
            .tick    (tick_vec[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: a phase-based reference model predicts
// cfg_ready, clk_out and tick; a monitor process pops and compares them.
module tb_clk_div_multi;
    import clk_div_pkg::*;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 16;
    localparam int CH_W   = ch_width(NUM_CH);

    typedef struct {
        logic [NUM_CH-1:0] clk;
        logic [NUM_CH-1:0] tick;
    } exp_t;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    logic align = 1'b0;

    int n_vectors = 0;
    int n_miss    = 0;

    exp_t out_q[$];
    logic ready_q[$];

    int m_ph   [NUM_CH];
    int m_n    [NUM_CH];
    int m_h    [NUM_CH];
    int m_shn  [NUM_CH];
    int m_shh  [NUM_CH];
    bit m_pend [NUM_CH];

    always #5 CLK = ~CLK;

    clk_div_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    clk_div_multi #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .DEF_DIV (4),
        .DEF_HI  (2)
    ) dut (
        .CLK   (CLK),
        .rst   (rst),
`ifdef CLK_DIV_PHASE_ALIGN_EN
        .align (align),
`endif
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_ph[i]   = 0;
            m_n[i]    = 4;
            m_h[i]    = 2;
            m_shn[i]  = 4;
            m_shh[i]  = 2;
            m_pend[i] = 1'b0;
        end
    endtask

    // Model: each channel is a phase position within a period of N cycles, high
    // for the last H of them; reconfiguration waits for the end of a period.
    task automatic applyStimulus(input logic [NUM_CH-1:0] e, input logic v, input int ch,
                                 input int d, input int h, input logic a);
        exp_t x;
        bit   acc;
        bit   al;
        int   nn;
        int   hh;
        int   nxt;
        @(negedge CLK);
        bus.en        = e;
        bus.cfg_valid = v;
        bus.cfg_ch    = CH_W'(ch);
        bus.cfg_div   = CNT_W'(d);
        bus.cfg_hi    = CNT_W'(h);
`ifdef CLK_DIV_PHASE_ALIGN_EN
        align = a;
        al    = a;
`else
        al    = 1'b0;
`endif
        ready_q.push_back(!m_pend[ch]);
        acc = v && !m_pend[ch];
        for (int i = 0; i < NUM_CH; i++) begin
            if (!e[i] || al) begin
                x.clk[i]  = 1'b0;
                x.tick[i] = 1'b0;
                nxt       = 0;
            end else begin
                x.clk[i]  = (m_ph[i] >= m_n[i] - m_h[i]);
                x.tick[i] = (m_ph[i] == m_n[i] - 1);
                nxt       = (m_ph[i] + 1) % m_n[i];
            end
            if (m_pend[i] && (!e[i] || al || m_ph[i] == m_n[i] - 1)) begin
                m_n[i]    = m_shn[i];
                m_h[i]    = m_shh[i];
                m_pend[i] = 1'b0;
            end
            m_ph[i] = nxt;
        end
        if (acc) begin
            nn = (d < 2) ? 2 : d;
            hh = (h == 0) ? 1 : h;
            if (hh > nn - 1) hh = nn - 1;
            m_shn[ch]  = nn;
            m_shh[ch]  = hh;
            m_pend[ch] = 1'b1;
        end
        out_q.push_back(x);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) applyStimulus('1, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic midReset();
        @(negedge CLK);
        bus.en        = '0;
        bus.cfg_valid = 1'b0;
        align         = 1'b0;
        #3 rst = 1'b1;
        #1;
        checkOutput("midrst_clk_out", 32'(bus.clk_out), 32'd0);
        checkOutput("midrst_tick", 32'(bus.tick), 32'd0);
        checkOutput("midrst_ready", 32'(bus.cfg_ready), 32'd1);
        @(negedge CLK);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin : monitor
        logic r;
        exp_t x;
        forever begin
            @(negedge CLK);
            #2;
            if (ready_q.size() > 0) begin
                r = ready_q.pop_front();
                checkOutput("cfg_ready", 32'(bus.cfg_ready), 32'(r));
            end
            @(posedge CLK);
            #1;
            if (out_q.size() > 0) begin
                x = out_q.pop_front();
                checkOutput("clk_out", 32'(bus.clk_out), 32'(x.clk));
                checkOutput("tick", 32'(bus.tick), 32'(x.tick));
            end
        end
    end

    initial begin : stimulus
        logic [NUM_CH-1:0] e;
        bus.en        = '0;
        bus.cfg_valid = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_div   = '0;
        bus.cfg_hi    = '0;
        rst           = 1'b1;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("rst_clk_out", 32'(bus.clk_out), 32'd0);
        checkOutput("rst_tick", 32'(bus.tick), 32'd0);
        checkOutput("rst_ready", 32'(bus.cfg_ready), 32'd1);
        @(negedge CLK);
        rst = 1'b0;

        idle(12);
        repeat (6) applyStimulus('1, 1'b1, 0, 10, 3, 1'b0);
        idle(25);
        applyStimulus('1, 1'b1, 1, 1, 0, 1'b0);
        idle(10);
        applyStimulus('1, 1'b1, 1, 5, 9, 1'b0);
        idle(15);
        repeat (3) applyStimulus(2'b10, 1'b0, 0, 0, 0, 1'b0);
        idle(10);
        applyStimulus('1, 1'b1, 1, 8, 5, 1'b0);
        midReset();
        idle(12);
`ifdef CLK_DIV_PHASE_ALIGN_EN
        applyStimulus('1, 1'b1, 0, 6, 3, 1'b0);
        idle(8);
        applyStimulus('1, 1'b0, 0, 0, 0, 1'b1);
        idle(26);
`endif
        for (int k = 0; k < 400; k++) begin
            e = ($urandom_range(15) == 0) ? NUM_CH'($urandom) : '1;
            applyStimulus(e, ($urandom_range(3) == 0), int'($urandom_range(NUM_CH - 1)),
                          int'($urandom_range(12)), int'($urandom_range(14)),
                          ($urandom_range(31) == 0));
        end

        repeat (3) @(posedge CLK);
        #2;
        checkOutput("scoreboard_drain", 32'(ready_q.size() + out_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miss);
        $finish;
    end

endmodule
